// File: rtl/xbar_rr_arb_pkg.sv
// Shared crossbar arbiter defaults and FSM state encoding.
// Kept in one place so the arbiter and its bench decode states the same way.
package xbar_rr_arb_pkg;

    localparam int XBAR_N        = 4;
    localparam int XBAR_SW       = 2;
    localparam int XBAR_HOLD_MAX = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/xbar_rr_pick.sv
// Round-robin pick: first requesting index at or after ptr, wrapping modulo N.
// Purely combinational; the owning arbiter registers the result.
module xbar_rr_pick #(
    parameter int N  = 4,
    parameter int SW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] idx,
    output logic          any
);

    int cand;

    // Walk the rotated request vector from ptr and take the first hit.
    // The wrap is modulo N, not modulo 2**SW, so unused codes never appear.
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = SW'(cand);
            end
        end
    end

endmodule

// File: rtl/xbar_rr_arb.sv
// Per-output round-robin arbiter for the crossbar; drives the N:1 mux select.
// Grants are registered, held until release, and force-released at HOLD_MAX.
module xbar_rr_arb
    import xbar_rr_arb_pkg::*;
#(
    parameter int N        = XBAR_N,
    parameter int SW       = XBAR_SW,
    parameter int HOLD_MAX = XBAR_HOLD_MAX
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          done,
    output logic [SW-1:0] sel,
    output logic [N-1:0]  gnt,
    output logic          busy,
    output logic          timeout
);

    arb_state_e    state;
    arb_state_e    state_d;
    logic [SW-1:0] ptr;
    logic [SW-1:0] ptr_d;
    logic [15:0]   hold_cnt;
    logic [15:0]   hold_d;
    logic [SW-1:0] sel_d;
    logic [N-1:0]  gnt_d;
    logic          busy_d;
    logic          timeout_d;
    logic [SW-1:0] pick_idx;
    logic          pick_any;
    logic          own_req;
    logic          at_limit;

    xbar_rr_pick #(
        .N  (N),
        .SW (SW)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign own_req  = req[sel];
    assign at_limit = (hold_cnt == 16'(HOLD_MAX));

    // Next-state logic: registers hold by default, timeout only pulses.
    // Releasing always lands in IDLE, which guarantees one gnt=0 bubble.
    always_comb begin
        state_d   = state;
        sel_d     = sel;
        gnt_d     = gnt;
        busy_d    = busy;
        timeout_d = 1'b0;
        ptr_d     = ptr;
        hold_d    = hold_cnt;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_GRANT;
                    sel_d   = pick_idx;
                    busy_d  = 1'b1;
                    hold_d  = 16'd1;
                    for (int i = 0; i < N; i++) begin
                        gnt_d[i] = (pick_idx == SW'(i));
                    end
                end
            end
            ST_GRANT: begin
                if (done || !own_req || at_limit) begin
                    state_d   = ST_IDLE;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    hold_d    = 16'd0;
                    ptr_d     = (sel == SW'(N - 1)) ? '0 : sel + SW'(1);
                    timeout_d = at_limit && !done && own_req;
                end else if (hold_cnt != 16'hFFFF) begin
                    hold_d = hold_cnt + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            sel      <= '0;
            gnt      <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            ptr      <= '0;
            hold_cnt <= 16'd0;
        end else begin
            state    <= state_d;
            sel      <= sel_d;
            gnt      <= gnt_d;
            busy     <= busy_d;
            timeout  <= timeout_d;
            ptr      <= ptr_d;
            hold_cnt <= hold_d;
        end
    end

endmodule

// File: tb/tb_xbar_rr_arb.sv
// Directed bench for xbar_rr_arb: reset, single grant, fairness, wrap,
// hold-limit timeout, mid-grant request drop and reset during a grant.
module tb_xbar_rr_arb;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       busy;
    logic       timeout;

    int vectors;
    int miscompares;

    xbar_rr_arb #(
        .N        (4),
        .SW       (2),
        .HOLD_MAX (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .sel     (sel),
        .gnt     (gnt),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [3:0] r, input logic d, input logic rs);
        req  = r;
        done = d;
        rst  = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] es, input logic [3:0] eg,
                               input logic eb, input logic et);
        vectors++;
        assert (sel === es) else begin
            miscompares++;
            $error("[TB] FAIL %s sel: observed %0d expected %0d", tag, sel, es);
        end
        vectors++;
        assert (gnt === eg) else begin
            miscompares++;
            $error("[TB] FAIL %s gnt: observed %b expected %b", tag, gnt, eg);
        end
        vectors++;
        assert (busy === eb) else begin
            miscompares++;
            $error("[TB] FAIL %s busy: observed %b expected %b", tag, busy, eb);
        end
        vectors++;
        assert (timeout === et) else begin
            miscompares++;
            $error("[TB] FAIL %s timeout: observed %b expected %b", tag, timeout, et);
        end
    endtask

    task automatic checkPtr(input string tag, input logic [1:0] ep);
        vectors++;
        assert (dut.ptr === ep) else begin
            miscompares++;
            $error("[TB] FAIL %s ptr: observed %0d expected %0d", tag, dut.ptr, ep);
        end
    endtask

    initial begin
        logic [1:0] order [5];
        logic [3:0] all_req;
        order       = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        all_req     = 4'b1111;
        vectors     = 0;
        miscompares = 0;
        req         = 4'b0000;
        done        = 1'b0;
        rst         = 1'b1;

        $display("[TB] reset then idle");
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkOutput("reset_c0", 2'd0, 4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b1);
        checkOutput("reset_c1", 2'd0, 4'b0000, 1'b0, 1'b0);
        checkPtr("reset_ptr", 2'd0);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("idle", 2'd0, 4'b0000, 1'b0, 1'b0);

        $display("[TB] round-robin fairness");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(all_req, 1'b0, 1'b0);
            checkOutput("rr_first", order[k], 4'b0001 << order[k], 1'b1, 1'b0);
            applyStimulus(all_req, 1'b0, 1'b0);
            checkOutput("rr_second", order[k], 4'b0001 << order[k], 1'b1, 1'b0);
            applyStimulus(all_req, 1'b1, 1'b0);
            checkOutput("rr_bubble", order[k], 4'b0000, 1'b0, 1'b0);
        end
        checkPtr("rr_ptr", 2'd1);

        $display("[TB] single requester");
        applyStimulus(4'b0100, 1'b0, 1'b0);
        checkOutput("single_c1", 2'd2, 4'b0100, 1'b1, 1'b0);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        checkOutput("single_c2", 2'd2, 4'b0100, 1'b1, 1'b0);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        checkOutput("single_c3", 2'd2, 4'b0100, 1'b1, 1'b0);
        applyStimulus(4'b0100, 1'b1, 1'b0);
        checkOutput("single_rel", 2'd2, 4'b0000, 1'b0, 1'b0);
        checkPtr("single_ptr", 2'd3);

        $display("[TB] wrap with gaps");
        applyStimulus(4'b0011, 1'b0, 1'b0);
        checkOutput("wrap_g0", 2'd0, 4'b0001, 1'b1, 1'b0);
        applyStimulus(4'b0011, 1'b1, 1'b0);
        checkOutput("wrap_rel0", 2'd0, 4'b0000, 1'b0, 1'b0);
        checkPtr("wrap_ptr1", 2'd1);
        applyStimulus(4'b0011, 1'b0, 1'b0);
        checkOutput("wrap_g1", 2'd1, 4'b0010, 1'b1, 1'b0);
        applyStimulus(4'b0011, 1'b1, 1'b0);
        checkOutput("wrap_rel1", 2'd1, 4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("wrap_idle", 2'd1, 4'b0000, 1'b0, 1'b0);
        checkPtr("wrap_ptr2", 2'd2);

        $display("[TB] hold limit");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(4'b0010, 1'b0, 1'b0);
            checkOutput("hold_grant", 2'd1, 4'b0010, 1'b1, 1'b0);
        end
        applyStimulus(4'b0010, 1'b0, 1'b0);
        checkOutput("hold_timeout", 2'd1, 4'b0000, 1'b0, 1'b1);
        checkPtr("hold_ptr", 2'd2);
        applyStimulus(4'b0010, 1'b0, 1'b0);
        checkOutput("hold_regrant", 2'd1, 4'b0010, 1'b1, 1'b0);

        $display("[TB] request drop mid-grant");
        applyStimulus(4'b0010, 1'b0, 1'b0);
        checkOutput("drop_c2", 2'd1, 4'b0010, 1'b1, 1'b0);
        applyStimulus(4'b1000, 1'b0, 1'b0);
        checkOutput("drop_rel", 2'd1, 4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b1000, 1'b0, 1'b0);
        checkOutput("drop_next", 2'd3, 4'b1000, 1'b1, 1'b0);

        $display("[TB] reset during grant");
        applyStimulus(4'b1000, 1'b0, 1'b1);
        checkOutput("rst_grant", 2'd0, 4'b0000, 1'b0, 1'b0);
        checkPtr("rst_ptr", 2'd0);
        applyStimulus(4'b1000, 1'b0, 1'b0);
        checkOutput("post_rst_g", 2'd3, 4'b1000, 1'b1, 1'b0);

        $display("[TB] done coincides with hold limit");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b1000, 1'b0, 1'b0);
            checkOutput("coinc_hold", 2'd3, 4'b1000, 1'b1, 1'b0);
        end
        applyStimulus(4'b1000, 1'b1, 1'b0);
        checkOutput("coinc_rel", 2'd3, 4'b0000, 1'b0, 1'b0);
        checkPtr("coinc_ptr", 2'd0);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("final_idle", 2'd3, 4'b0000, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
